// File: rtl/core_tile_buf.sv
`default_nettype none
// ============================================================================
// Module      : core_tile_buf
// Description : Single 8x8 RGB tile buffer. The DMA side writes four byte lanes
//               per beat and the rotation side reads one RGB triple per beat.
//               A fill/drain FSM prevents a tile from being overwritten while
//               it is still being read.
//               Optional macro CORE_TILE_BUF_ERR_EN adds the sticky O_ERR flag.
// Revision    : 1.0 - initial release
// ============================================================================
module core_tile_buf #(
    parameter int DEPTH  = 192,
    parameter int ADDR_W = 8
) (
    input  logic              I_HCLK,
    input  logic              I_HRESET,
    input  logic              I_WR_EN,
    input  logic [ADDR_W-1:0] I_WR_ADDR0,
    input  logic [ADDR_W-1:0] I_WR_ADDR1,
    input  logic [ADDR_W-1:0] I_WR_ADDR2,
    input  logic [ADDR_W-1:0] I_WR_ADDR3,
    input  logic [31:0]       I_WR_DATA,
    input  logic              I_RD_EN,
    input  logic [ADDR_W-1:0] I_RD_ADDRR,
    input  logic [ADDR_W-1:0] I_RD_ADDRG,
    input  logic [ADDR_W-1:0] I_RD_ADDRB,
    output logic [23:0]       O_RD_DATA,
    output logic              O_RD_VALID,
    output logic              O_WR_RDY,
    output logic              O_RD_RDY,
    output logic              O_EMPTY,
    output logic              O_FULL
`ifdef CORE_TILE_BUF_ERR_EN
    ,
    input  logic              I_ERR_CLR,
    output logic              O_ERR
`endif
);

    localparam int WORDS  = DEPTH / 4;
    localparam int PIXELS = DEPTH / 3;

    localparam logic [5:0]    c_WORD_LAST = 6'(WORDS - 1);
    localparam logic [5:0]    c_PIX_LAST  = 6'(PIXELS - 1);
    localparam logic [ADDR_W:0] c_DEPTH   = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_FILLING  = 2'd1,
        ST_FULL     = 2'd2,
        ST_DRAINING = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic [5:0] r_wcnt;
    logic [5:0] w_wcnt_nxt;
    logic [5:0] r_rcnt;
    logic [5:0] w_rcnt_nxt;

    logic [7:0] r_mem [DEPTH];

    logic [ADDR_W-1:0] w_wr_addr [4];
    logic [7:0]        w_wr_byte [4];
    logic [3:0]        w_wr_ok;
    logic [ADDR_W-1:0] w_rd_addr [3];
    logic [7:0]        w_rd_byte [3];
    logic [2:0]        w_rd_ok;

    logic w_wr_rdy;
    logic w_rd_rdy;
    logic w_wr_acc;
    logic w_rd_acc;

    logic [23:0] r_rd_data;
    logic        r_rd_valid;

    assign w_wr_rdy = (r_state == ST_EMPTY) || (r_state == ST_FILLING);
    assign w_rd_rdy = (r_state == ST_FULL)  || (r_state == ST_DRAINING);
    assign w_wr_acc = I_WR_EN && w_wr_rdy;
    assign w_rd_acc = I_RD_EN && w_rd_rdy;

    assign w_wr_addr[0] = I_WR_ADDR0;
    assign w_wr_addr[1] = I_WR_ADDR1;
    assign w_wr_addr[2] = I_WR_ADDR2;
    assign w_wr_addr[3] = I_WR_ADDR3;

    assign w_rd_addr[0] = I_RD_ADDRR;
    assign w_rd_addr[1] = I_RD_ADDRG;
    assign w_rd_addr[2] = I_RD_ADDRB;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wr_lane
            assign w_wr_byte[gi] = I_WR_DATA[8*gi +: 8];
            assign w_wr_ok[gi]   = ({1'b0, w_wr_addr[gi]} < c_DEPTH);
        end
        // Out-of-range read lanes return zero instead of indexing past the array
        for (genvar gj = 0; gj < 3; gj++) begin : g_rd_lane
            assign w_rd_ok[gj]   = ({1'b0, w_rd_addr[gj]} < c_DEPTH);
            assign w_rd_byte[gj] = w_rd_ok[gj] ? r_mem[w_rd_addr[gj]] : 8'h00;
        end
    endgenerate

    // Storage is deliberately left out of reset
    always_ff @(posedge I_HCLK) begin
        if (w_wr_acc) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wr_ok[i]) begin
                    r_mem[w_wr_addr[i]] <= w_wr_byte[i];
                end
            end
        end
    end

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            r_state <= ST_EMPTY;
            r_wcnt  <= 6'd0;
            r_rcnt  <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_rcnt  <= w_rcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_rcnt_nxt  = r_rcnt;
        case (r_state)
            ST_EMPTY: begin
                if (w_wr_acc) begin
                    w_state_nxt = ST_FILLING;
                    w_wcnt_nxt  = 6'd1;
                end
            end
            ST_FILLING: begin
                if (w_wr_acc) begin
                    if (r_wcnt == c_WORD_LAST) begin
                        w_state_nxt = ST_FULL;
                        w_wcnt_nxt  = 6'd0;
                    end else begin
                        w_wcnt_nxt  = r_wcnt + 6'd1;
                    end
                end
            end
            ST_FULL: begin
                if (w_rd_acc) begin
                    w_state_nxt = ST_DRAINING;
                    w_rcnt_nxt  = 6'd1;
                end
            end
            ST_DRAINING: begin
                if (w_rd_acc) begin
                    if (r_rcnt == c_PIX_LAST) begin
                        w_state_nxt = ST_EMPTY;
                        w_rcnt_nxt  = 6'd0;
                    end else begin
                        w_rcnt_nxt  = r_rcnt + 6'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
                w_wcnt_nxt  = 6'd0;
                w_rcnt_nxt  = 6'd0;
            end
        endcase
    end

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            r_rd_data  <= 24'h0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= {w_rd_byte[0], w_rd_byte[1], w_rd_byte[2]};
            end
        end
    end

    assign O_RD_DATA  = r_rd_data;
    assign O_RD_VALID = r_rd_valid;
    assign O_WR_RDY   = w_wr_rdy;
    assign O_RD_RDY   = w_rd_rdy;
    assign O_EMPTY    = (r_state == ST_EMPTY);
    assign O_FULL     = (r_state == ST_FULL);

`ifdef CORE_TILE_BUF_ERR_EN
    logic r_err;
    logic w_err_set;

    assign w_err_set = (I_WR_EN && !w_wr_rdy)
                    || (I_RD_EN && !w_rd_rdy)
                    || (w_wr_acc && !(&w_wr_ok))
                    || (w_rd_acc && !(&w_rd_ok));

    // A new error in the clearing cycle must not be lost
    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (I_ERR_CLR) begin
            r_err <= 1'b0;
        end
    end

    assign O_ERR = r_err;
`else
    // Illegal requests are dropped silently; no error state is kept.
`endif

endmodule
`default_nettype wire
